mem_stage: RTL and testbench

Memory-access stage of the five-stage ARM-subset pipeline. It consumes the EXE/MEM pipeline register outputs (ALU result, Rm store value, memory/write-back controls, destination register) and performs loads and stores through a multi-cycle external SRAM controller. It raises `ready` low while an access is in progress; the top level derives pipeline `freeze` as `~ready`. It also contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - SRAM bus between the memory stage and the external SRAM controller
interface mem_stage_if #(
  parameter int SRAM_AW = 16
);
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    output sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    input  sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: multi-cycle SRAM access FSM plus MEM/WB register
module mem_stage #(
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 16,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        wb_enable_in,
  input  logic [3:0]  dest_reg_in,
  output logic        ready,
  mem_stage_if.master sram,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out
);

  localparam int               CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      load_data;
  logic             mem_req;
  logic             is_load;
  logic             we_n;
  logic             oe_n;

  assign mem_req = mem_read_in | mem_write_in;
  // A simultaneous read and write request is handled purely as a store.
  assign is_load = mem_read_in & ~mem_write_in;

  assign sram.sram_addr  = SRAM_AW'((alu_result_in - $unsigned(32'(ADDR_BASE))) >> 2);
  assign sram.sram_wdata = val_rm_in;
  assign sram.sram_we_n  = we_n;
  assign sram.sram_oe_n  = oe_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes decode only the registered state, so they cannot pulse outside ACCESS.
  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    case (state)
      IDLE: begin
        if (mem_req) begin
          ready     = 1'b0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ready = 1'b0;
        if (mem_write_in) we_n = 1'b0;
        else              oe_n = 1'b0;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (state == IDLE)   cnt <= '0;
    else if (state == ACCESS) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_data <= '0;
    else if (state == ACCESS && cnt == LAST && is_load) load_data <= sram.sram_rdata;
  end

  // While stalled, inject a bubble; payload fields hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
    end else if (ready) begin
      wb_en_out      <= wb_enable_in;
      mem_read_out   <= mem_read_in;
      dest_out       <= dest_reg_in;
      alu_result_out <= alu_result_in;
      mem_data_out   <= load_data;
    end else begin
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage with a behavioural SRAM
module tb_mem_stage;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result_in = '0;
  logic [31:0] val_rm_in = '0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        wb_enable_in = 1'b0;
  logic [3:0]  dest_reg_in = '0;
  logic        ready;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wb;
    logic        mr;
    logic [3:0]  dst;
    logic [31:0] alu;
    logic [31:0] md;
  } exp_t;
  exp_t sb[$];

  logic [31:0] sram_mem [0:65535];

  mem_stage_if #(.SRAM_AW(16)) bus ();

  mem_stage #(.ADDR_BASE(1024), .SRAM_AW(16), .WAIT_CYCLES(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result_in  (alu_result_in),
    .val_rm_in      (val_rm_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .wb_enable_in   (wb_enable_in),
    .dest_reg_in    (dest_reg_in),
    .ready          (ready),
    .sram           (bus),
    .wb_en_out      (wb_en_out),
    .mem_read_out   (mem_read_out),
    .dest_out       (dest_out),
    .alu_result_out (alu_result_out),
    .mem_data_out   (mem_data_out)
  );

  always #5 clk = ~clk;

  assign bus.sram_rdata = bus.sram_oe_n ? 32'h0 : sram_mem[bus.sram_addr];

  always @(posedge clk) begin
    if (!rst && !bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one instruction at a negedge and follows it until it retires.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] rm,
                        input logic rd, input logic wr, input logic wb, input logic [3:0] dst,
                        input logic [15:0] exp_addr, input logic [31:0] exp_md);
    exp_t e;
    exp_t got;
    int   stall = 0;
    int   we_cnt = 0;
    int   oe_cnt = 0;
    bit   done = 0;
    e.wb = wb; e.mr = rd; e.dst = dst; e.alu = alu; e.md = exp_md;
    sb.push_back(e);
    alu_result_in = alu; val_rm_in = rm; mem_read_in = rd; mem_write_in = wr;
    wb_enable_in = wb; dest_reg_in = dst;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (ready) done = 1;
      else stall++;
      if (!bus.sram_we_n) we_cnt++;
      if (!bus.sram_oe_n) oe_cnt++;
      if (c == 1 && (rd || wr)) check({tag, "_addr"}, 32'(bus.sram_addr), 32'(exp_addr));
      @(negedge clk);
      if (!done) check({tag, "_bubble"}, {31'b0, wb_en_out | mem_read_out}, 32'd0);
    end
    check({tag, "_retired"}, 32'(done), 32'd1);
    check({tag, "_stall"}, stall, (rd || wr) ? W + 1 : 0);
    check({tag, "_we_cycles"}, we_cnt, wr ? W : 0);
    check({tag, "_oe_cycles"}, oe_cnt, (rd && !wr) ? W : 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_wb_en"}, 32'(wb_en_out), 32'(got.wb));
      check({tag, "_mem_read"}, 32'(mem_read_out), 32'(got.mr));
      check({tag, "_dest"}, 32'(dest_out), 32'(got.dst));
      check({tag, "_alu"}, alu_result_out, got.alu);
      check({tag, "_mem_data"}, mem_data_out, got.md);
    end
  endtask

  task automatic idle_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0; wb_enable_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = 32'h0;
    sram_mem[3] = 32'h12345678;

    @(negedge clk); #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("rst_outs", {wb_en_out, mem_read_out, dest_out, 26'b0} | alu_result_out | mem_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("alu", 32'h55, 32'h0, 0, 0, 1, 4'd3, 16'h0, 32'h0);
    run_op("store", 32'd1032, 32'hDEADBEEF, 0, 1, 0, 4'd0, 16'd2, 32'h0);
    check("store_mem", sram_mem[2], 32'hDEADBEEF);
    run_op("load", 32'd1032, 32'h0, 1, 0, 1, 4'd5, 16'd2, 32'hDEADBEEF);
    run_op("b2b_ld", 32'd1036, 32'h0, 1, 0, 1, 4'd6, 16'd3, 32'h12345678);
    run_op("b2b_st", 32'd1040, 32'hCAFEF00D, 0, 1, 0, 4'd7, 16'd4, 32'h12345678);
    check("b2b_mem", sram_mem[4], 32'hCAFEF00D);
    run_op("wrap_both", 32'd1020, 32'hA5A5A5A5, 1, 1, 1, 4'd9, 16'hFFFF, 32'h12345678);
    check("wrap_mem", sram_mem[65535], 32'hA5A5A5A5);
    run_op("alu2", 32'h0000ABCD, 32'h0, 0, 0, 1, 4'd12, 16'h0, 32'h12345678);

    alu_result_in = 32'd1024; val_rm_in = 32'h11112222; mem_write_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_we_active", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_we_n", 32'(bus.sram_we_n), 32'd1);
    check("mid_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("mid_ready_req", 32'(ready), 32'd0);
    check("mid_outs", {wb_en_out, mem_read_out, dest_out, 26'b0} | alu_result_out | mem_data_out, 32'd0);
    idle_inputs();
    #1;
    check("mid_ready_idle", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'd1044, 32'h0BADF00D, 0, 1, 1, 4'd2, 16'd5, 32'h0);
    check("post_rst_mem", sram_mem[5], 32'h0BADF00D);
    idle_inputs();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
